// File: rtl/msk_sharing_fifo_pkg.sv
// rtl/msk_sharing_fifo_pkg.sv - share-layout and sizing helpers shared by the masked stages
package msk_sharing_fifo_pkg;

  // Width of one sharing: count masked bits, each split into d shares.
  function automatic int sharing_width(input int count, input int d);
    return count * d;
  endfunction

  // LSB of share j inside a sharing; share j occupies [j*count +: count].
  function automatic int share_lsb(input int j, input int count);
    return j * count;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/msk_fifo_ctrl.sv
// rtl/msk_fifo_ctrl.sv - pointer, level and handshake control for the sharing FIFO (MSKFIFO_ZEROIZE_EN)
module msk_fifo_ctrl
  import msk_sharing_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic          push,
  output logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   level,
  output logic          zero_we
);

  // Handshake status comes only from the level register, never from in_valid/out_ready.
  assign in_ready  = (level != (AW+1)'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef MSKFIFO_ZEROIZE_EN
  assign zero_we = pop;
`else
  assign zero_we = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/msk_sharing_fifo.sv
// rtl/msk_sharing_fifo.sv - lane-separated FIFO for masked sharings (optional MSKFIFO_ZEROIZE_EN)
module msk_sharing_fifo
  import msk_sharing_fifo_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [count*d-1:0]       in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [count*d-1:0]       out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [clog2(DEPTH):0]    level
);

  localparam int W  = sharing_width(count, d);
  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic          push;
  logic          pop;
  logic          zero_we;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  msk_fifo_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push),
    .pop       (pop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .level     (level),
    .zero_we   (zero_we)
  );

`ifdef MSKFIFO_ZEROIZE_EN
  // Popped slots are scrubbed; the push is written last so it wins on a shared slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (zero_we) begin
        mem[rd_ptr] <= '0;
      end
      if (push) begin
        mem[wr_ptr] <= in_data;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (zero_we) begin
      mem[rd_ptr] <= '0;
    end
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end
`endif

  // Each share lane gets its own read mux so no logic ever mixes shares.
  for (genvar j = 0; j < d; j++) begin : g_lane
    localparam int LSB = share_lsb(j, count);
    logic [count-1:0] lane_q;
    assign lane_q = mem[rd_ptr][LSB +: count];
`ifdef MSKFIFO_ZEROIZE_EN
    assign out_data[LSB +: count] = out_valid ? lane_q : '0;
`else
    assign out_data[LSB +: count] = lane_q;
`endif
  end

endmodule

// File: tb/tb_msk_sharing_fifo.sv
// tb/tb_msk_sharing_fifo.sv - randomized self-checking bench for msk_sharing_fifo
module tb_msk_sharing_fifo;

  localparam int D     = 2;
  localparam int COUNT = 4;
  localparam int DEP   = 4;
  localparam int W     = D * COUNT;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   level;

  int tests  = 0;
  int failed = 0;

  logic [W-1:0] q[$];
  int           pushes = 0;

  always #5 clk = ~clk;

  msk_sharing_fifo #(.d(D), .count(COUNT), .DEPTH(DEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    check("level", 32'(level), 32'(q.size()));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(q.size() != DEP));
    if (q.size() != 0) begin
      for (int j = 0; j < D; j++) begin
        check($sformatf("lane%0d", j), 32'(out_data[j*COUNT +: COUNT]), 32'(q[0][j*COUNT +: COUNT]));
      end
    end else begin
`ifdef MSKFIFO_ZEROIZE_EN
      check("empty_out_zero", 32'(out_data), 32'h0);
`endif
    end
  endtask

  // One clock: the model decides push/pop from its own occupancy, then compares after the edge.
  task automatic step(input logic v, input logic [W-1:0] dat, input logic r);
    logic         do_push;
    logic         do_pop;
    logic [W-1:0] tmp;
    in_valid  = v;
    in_data   = dat;
    out_ready = r;
    do_push = v && (q.size() < DEP);
    do_pop  = r && (q.size() > 0);
    @(posedge clk);
    #1;
    if (do_pop) tmp = q.pop_front();
    if (do_push) begin
      q.push_back(dat);
      pushes++;
    end
    check_state();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = W'($urandom);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q.delete();
    pushes = 0;
    check_state();
  endtask

  logic [W-1:0] exp_seq [4];
  int           slot;

  initial begin
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("reset_level", 32'(level), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);

    // 1: single push, fall-through after one edge
    step(1'b1, 8'h3C, 1'b0);
    check("t1_data", 32'(out_data), 32'h3C);
    check("t1_level", 32'(level), 32'h1);
    step(1'b0, 8'h00, 1'b1);

    // 2: fill, dropped fifth push, ordered drain
    for (int i = 0; i < 4; i++) step(1'b1, exp_seq[i], 1'b0);
    check("t2_full_ready", 32'(in_ready), 32'h0);
    step(1'b1, 8'h55, 1'b0);
    check("t2_full_level", 32'(level), 32'h4);
    for (int i = 0; i < 4; i++) begin
      check("t2_order", 32'(out_data), 32'(exp_seq[i]));
      step(1'b0, 8'h00, 1'b1);
    end
    check("t2_empty_level", 32'(level), 32'h0);

    // 3: full, push+pop same cycle -> pop only
    for (int i = 0; i < 4; i++) step(1'b1, exp_seq[i], 1'b0);
    check("t3_head", 32'(out_data), 32'h11);
    step(1'b1, 8'h55, 1'b1);
    check("t3_level", 32'(level), 32'h3);
    check("t3_ready", 32'(in_ready), 32'h1);
    check("t3_next", 32'(out_data), 32'h22);

    // 4: drain to level 2, then 10 simultaneous push/pop cycles across the wrap
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, W'($urandom), 1'b1);
      check("t4_level", 32'(level), 32'h2);
    end

    // 5: reset with three entries held and a push/pop presented
    step(1'b1, 8'h77, 1'b0);
    check("t5_pre_level", 32'(level), 32'h3);
    do_reset();
    check("t5_level", 32'(level), 32'h0);
    check("t5_valid", 32'(out_valid), 32'h0);
`ifdef MSKFIFO_ZEROIZE_EN
    check("t5_out_zero", 32'(out_data), 32'h0);
`endif

    // 6: scrubbing of a popped slot
    step(1'b1, 8'hA5, 1'b0);
    slot = (pushes - 1) % DEP;
    step(1'b0, 8'h00, 1'b1);
`ifdef MSKFIFO_ZEROIZE_EN
    check("t6_slot_zero", 32'(dut.mem[slot]), 32'h0);
    check("t6_out_zero", 32'(out_data), 32'h0);
`endif

    // Random traffic with phases biased toward filling and draining
    for (int i = 0; i < 600; i++) begin
      int pv;
      int pr;
      pv = ((i / 50) % 2 == 0) ? 80 : 30;
      pr = ((i / 50) % 2 == 0) ? 30 : 80;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 99) < pv), W'($urandom), 1'($urandom_range(0, 99) < pr));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
